// File: rtl/uart_frame_sender.sv
// uart_frame_sender
// Serialises one latched command frame (address + 16-bit data) into five
// bytes for a UART transmitter: HEADER, addr, data[15:8], data[7:0], and an
// XOR checksum. Each byte goes out with a one-cycle valid pulse. The next
// byte is issued only after the transmitter reports done. Frame completion
// is signalled with a one-cycle pulse.
//
// Handshake: o_Tx_DV is a single-cycle strobe. o_Tx_Byte is valid on that
// cycle and holds until the next strobe. A byte counts as consumed on the
// rising edge of i_Tx_Done, so a done level held for several cycles counts
// once. No strobe is issued while i_Tx_Active is high.
module uart_frame_sender #(
    parameter logic [7:0] HEADER   = 8'hAA,
    parameter int         GAP_CLKS = 0
) (
    input  logic        i_Clock,
    input  logic        i_Reset,
    input  logic        i_Start,
    input  logic [7:0]  i_Addr,
    input  logic [15:0] i_Data,
    output logic        o_Busy,
    output logic        o_Frame_Done,
    output logic        o_Tx_DV,
    output logic [7:0]  o_Tx_Byte,
    input  logic        i_Tx_Active,
    input  logic        i_Tx_Done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ISSUE     = 3'd1,
        S_WAIT_DONE = 3'd2,
        S_GAP       = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    // Last gap count before re-issuing. It is only meaningful when GAP_CLKS > 0.
    localparam logic [7:0] GAP_LAST = 8'(GAP_CLKS - 1);
    localparam bit         HAS_GAP  = (GAP_CLKS != 0);
    localparam logic [2:0] LAST_IDX = 3'd4;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  gap_q, gap_d;
    logic        done_q;
    logic [7:0]  addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        tx_dv_q, tx_dv_d;
    logic [7:0]  tx_byte_q, tx_byte_d;
    logic        busy_q, busy_d;
    logic        frame_done_q, frame_done_d;

    logic        done_rise;
    logic [7:0]  checksum;
    logic [7:0]  byte_sel;
    logic        gap_hit;

    assign done_rise = i_Tx_Done & ~done_q;
    assign checksum  = HEADER ^ addr_q ^ data_q[15:8] ^ data_q[7:0];
    assign gap_hit   = (gap_q == GAP_LAST);

    // Pick the byte for the current index from the latched frame.
    always_comb begin
        byte_sel = 8'h00;
        case (idx_q)
            3'd0:    byte_sel = HEADER;
            3'd1:    byte_sel = addr_q;
            3'd2:    byte_sel = data_q[15:8];
            3'd3:    byte_sel = data_q[7:0];
            3'd4:    byte_sel = checksum;
            default: byte_sel = 8'h00;
        endcase
    end

    // State register. Reset has priority over everything else.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (i_Start) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (!i_Tx_Active) state_d = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (done_rise) begin
                    if (idx_q == LAST_IDX) state_d = S_FINISH;
                    else if (HAS_GAP)      state_d = S_GAP;
                    else                   state_d = S_ISSUE;
                end
            end
            S_GAP: begin
                if (gap_hit) state_d = S_ISSUE;
            end
            S_FINISH: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Next values of the frame registers and registered outputs.
    always_comb begin
        idx_d        = idx_q;
        gap_d        = gap_q;
        addr_d       = addr_q;
        data_d       = data_q;
        tx_dv_d      = 1'b0;
        tx_byte_d    = tx_byte_q;
        busy_d       = busy_q;
        frame_done_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_Start) begin
                    addr_d = i_Addr;
                    data_d = i_Data;
                    idx_d  = 3'd0;
                    busy_d = 1'b1;
                end
            end
            S_ISSUE: begin
                if (!i_Tx_Active) begin
                    tx_dv_d   = 1'b1;
                    tx_byte_d = byte_sel;
                end
            end
            S_WAIT_DONE: begin
                if (done_rise && (idx_q != LAST_IDX)) begin
                    idx_d = idx_q + 3'd1;
                    if (HAS_GAP) gap_d = 8'd0;
                end
            end
            S_GAP: begin
                // Compare before increment so the counter never wraps.
                if (!gap_hit) gap_d = gap_q + 8'd1;
            end
            S_FINISH: begin
                frame_done_d = 1'b1;
                busy_d       = 1'b0;
            end
            default: begin
                idx_d     = 3'd0;
                gap_d     = 8'd0;
                tx_byte_d = 8'h00;
                busy_d    = 1'b0;
            end
        endcase
    end

    // Frame, counter, done-history and output registers.
    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            idx_q        <= 3'd0;
            gap_q        <= 8'd0;
            done_q       <= 1'b0;
            addr_q       <= 8'h00;
            data_q       <= 16'h0000;
            tx_dv_q      <= 1'b0;
            tx_byte_q    <= 8'h00;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            idx_q        <= idx_d;
            gap_q        <= gap_d;
            done_q       <= i_Tx_Done;
            addr_q       <= addr_d;
            data_q       <= data_d;
            tx_dv_q      <= tx_dv_d;
            tx_byte_q    <= tx_byte_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign o_Busy       = busy_q;
    assign o_Frame_Done = frame_done_q;
    assign o_Tx_DV      = tx_dv_q;
    assign o_Tx_Byte    = tx_byte_q;

endmodule

// File: tb/tb_uart_frame_sender.sv
// Testbench for uart_frame_sender: one instance without an inter-byte gap
// and one with a three-clock gap. Each instance has its own transmitter model.
module tb_uart_frame_sender;

  localparam logic [7:0] HDR  = 8'hAA;
  localparam int         GAP1 = 3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- per-instance signals ----------------
  logic        start     [2];
  logic [7:0]  addr      [2];
  logic [15:0] data      [2];
  logic        busy      [2];
  logic        fd        [2];
  logic        tx_dv     [2];
  logic [7:0]  tx_byte   [2];
  logic        tx_active [2];
  logic        tx_done   [2];

  uart_frame_sender #(.HEADER(HDR), .GAP_CLKS(0)) dut0 (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start[0]), .i_Addr(addr[0]),
    .i_Data(data[0]), .o_Busy(busy[0]), .o_Frame_Done(fd[0]),
    .o_Tx_DV(tx_dv[0]), .o_Tx_Byte(tx_byte[0]),
    .i_Tx_Active(tx_active[0]), .i_Tx_Done(tx_done[0])
  );

  uart_frame_sender #(.HEADER(HDR), .GAP_CLKS(GAP1)) dut1 (
    .i_Clock(clk), .i_Reset(rst), .i_Start(start[1]), .i_Addr(addr[1]),
    .i_Data(data[1]), .o_Busy(busy[1]), .o_Frame_Done(fd[1]),
    .o_Tx_DV(tx_dv[1]), .o_Tx_Byte(tx_byte[1]),
    .i_Tx_Active(tx_active[1]), .i_Tx_Done(tx_done[1])
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];

  int busy_left  [2];
  int done_left  [2];
  int force_left [2];
  int ref_cyc    [2];
  int ref_lat    [2];
  int byte_time  [2];
  int done_len   [2];
  int dv_cnt     [2];
  int fd_cnt     [2];
  int exp_frames [2];
  int gap_of     [2] = '{0, GAP1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  // Monitor, then transmitter model, on the falling edge of the clock.
  // The monitor runs first, so tx_active still holds the value that the
  // preceding rising edge sampled.
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        if (fd[k]) fd_cnt[k]++;
        if (tx_dv[k]) begin
          dv_cnt[k]++;
          check("dv_while_active", 32'(tx_active[k]), 32'd0);
          if (exp_q.size() == 0) check("dv_unexpected", 32'd1, 32'd0);
          else                   check("tx_byte", 32'(tx_byte[k]), 32'(exp_q.pop_front()));
          if (ref_cyc[k] >= 0) check("dv_latency", 32'(cyc - ref_cyc[k]), 32'(ref_lat[k]));
          ref_cyc[k] = -1;
        end
        // transmitter model
        if (tx_done[k]) begin
          if (done_left[k] > 0) done_left[k]--;
          else                  tx_done[k] = 1'b0;
        end
        if (force_left[k] > 0) begin
          force_left[k]--;
          if (force_left[k] == 0) begin
            tx_active[k] = 1'b0;
            ref_cyc[k]   = cyc;
            ref_lat[k]   = 1;
          end
        end else if (tx_dv[k]) begin
          tx_active[k] = 1'b1;
          busy_left[k] = byte_time[k];
        end else if (busy_left[k] > 0) begin
          busy_left[k]--;
          if (busy_left[k] == 0) begin
            tx_active[k] = 1'b0;
            tx_done[k]   = 1'b1;
            done_left[k] = done_len[k] - 1;
            ref_cyc[k]   = cyc;
            ref_lat[k]   = 2 + gap_of[k];
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame(input logic [7:0] a, input logic [15:0] d);
    exp_q.push_back(HDR);
    exp_q.push_back(a);
    exp_q.push_back(d[15:8]);
    exp_q.push_back(d[7:0]);
    exp_q.push_back(HDR ^ a ^ d[15:8] ^ d[7:0]);
  endtask

  task automatic run_frame(input int k, input logic [7:0] a, input logic [15:0] d,
                           input bit poke, input bit timed);
    int  dv0;
    int  busy_bad;
    bit  poked;
    dv0      = dv_cnt[k];
    busy_bad = 0;
    poked    = 1'b0;
    byte_time[k] = $urandom_range(2, 10);
    done_len[k]  = $urandom_range(1, 2);
    addr[k]  = a;
    data[k]  = d;
    start[k] = 1'b1;
    push_frame(a, d);
    exp_frames[k]++;
    if (timed) begin
      ref_cyc[k] = cyc;
      ref_lat[k] = 2;
    end
    tick();
    start[k] = 1'b0;
    check("busy_on_accept", 32'(busy[k]), 32'd1);
    for (int n = 0; n < 3000 && !fd[k]; n++) begin
      if (!busy[k]) busy_bad++;
      start[k] = 1'b0;
      if (poke && !poked && (dv_cnt[k] - dv0) == 3) begin
        start[k] = 1'b1;
        addr[k]  = ~a;
        data[k]  = d ^ 16'hFFFF;
        poked    = 1'b1;
      end
      tick();
    end
    start[k] = 1'b0;
    check("frame_done_seen", 32'(fd[k]), 32'd1);
    check("busy_hold", 32'(busy_bad), 32'd0);
    check("busy_at_done", 32'(busy[k]), 32'd0);
    check("dv_per_frame", 32'(dv_cnt[k] - dv0), 32'd5);
  endtask

  task automatic check_reset_outputs(input int k);
    check("rst_busy", 32'(busy[k]), 32'd0);
    check("rst_frame_done", 32'(fd[k]), 32'd0);
    check("rst_tx_dv", 32'(tx_dv[k]), 32'd0);
    check("rst_tx_byte", 32'(tx_byte[k]), 32'd0);
  endtask

  // watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0]  a;
    logic [15:0] d;
    int dv0;
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      start[k] = 1'b0; addr[k] = 8'h00; data[k] = 16'h0000;
      tx_active[k] = 1'b0; tx_done[k] = 1'b0;
      busy_left[k] = 0; done_left[k] = 0; force_left[k] = 0;
      ref_cyc[k] = -1; ref_lat[k] = 0; byte_time[k] = 4; done_len[k] = 2;
      dv_cnt[k] = 0; fd_cnt[k] = 0; exp_frames[k] = 0;
    end
    repeat (3) tick();
    check_reset_outputs(0);
    check_reset_outputs(1);
    rst = 1'b0;
    tick();

    // basic and checksum-edge frames, back to back, no gap
    run_frame(0, 8'h12, 16'h3456, 1'b0, 1'b1);
    run_frame(0, 8'hAA, 16'h0000, 1'b0, 1'b1);
    // random frames, some with a start pulse mid-frame
    for (int i = 0; i < 6; i++) begin
      run_frame(0, 8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
      if (i[0]) repeat ($urandom_range(1, 4)) tick();
    end
    repeat (3) tick();

    // reset mid-frame while the transmitter stays active
    a = 8'($urandom); d = 16'($urandom);
    byte_time[0] = 6; done_len[0] = 2;
    addr[0] = a; data[0] = d; start[0] = 1'b1;
    push_frame(a, d);
    ref_cyc[0] = cyc; ref_lat[0] = 2;
    dv0 = dv_cnt[0];
    tick();
    start[0] = 1'b0;
    for (int n = 0; n < 500 && (dv_cnt[0] - dv0) < 4; n++) tick();
    check("reached_byte3", 32'(dv_cnt[0] - dv0), 32'd4);
    tick();
    rst = 1'b1;
    force_left[0] = 40; tx_active[0] = 1'b1;
    busy_left[0] = 0; tx_done[0] = 1'b0; done_left[0] = 0;
    exp_q.delete();
    ref_cyc[0] = -1;
    tick();
    check_reset_outputs(0);
    rst = 1'b0;
    tick();
    run_frame(0, 8'($urandom), 16'($urandom), 1'b0, 1'b0);
    repeat (3) tick();

    // gap instance
    run_frame(1, 8'h12, 16'h3456, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      run_frame(1, 8'($urandom), 16'($urandom), 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (6) tick();
    check("frame_count0", 32'(fd_cnt[0]), 32'(exp_frames[0]));
    check("frame_count1", 32'(fd_cnt[1]), 32'(exp_frames[1]));
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
